// File: rtl/universal_shift_reg_param.sv
// ============================================================================
//  Module      : universal_shift_reg_param
//  Description : WIDTH-bit universal shift register (hold, shifts, rotates,
//                parallel load) with an autonomous MSB-first burst mode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module universal_shift_reg_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       sel,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] inp,
    output logic [WIDTH-1:0] out,
    output logic             msb_out,
    output logic             lsb_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    state_t             r_state_q, w_state_d;
    logic [WIDTH-1:0]   r_out_q,   w_out_d;
    logic [CNT_W-1:0]   r_cnt_q,   w_cnt_d;
    logic               r_busy_q,  w_busy_d;
    logic               r_done_q,  w_done_d;

    always_comb begin
        w_state_d = r_state_q;
        w_out_d   = r_out_q;
        w_cnt_d   = r_cnt_q;
        w_busy_d  = r_busy_q;
        w_done_d  = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (en) begin
                    case (sel)
                        3'b000: w_out_d = r_out_q;
                        3'b001: w_out_d = {r_out_q[WIDTH-2:0], serial_in};
                        3'b010: w_out_d = {serial_in, r_out_q[WIDTH-1:1]};
                        3'b011: w_out_d = inp;
                        3'b100: w_out_d = {r_out_q[WIDTH-2:0], r_out_q[WIDTH-1]};
                        3'b101: w_out_d = {r_out_q[0], r_out_q[WIDTH-1:1]};
                        3'b110: w_out_d = {r_out_q[WIDTH-1], r_out_q[WIDTH-1:1]};
                        default: begin
                            w_out_d   = inp;
                            w_cnt_d   = '0;
                            w_busy_d  = 1'b1;
                            w_state_d = S_BURST;
                        end
                    endcase
                end
            end
            default: begin
                // Shift out MSB-first while capturing serial_in at the LSB.
                w_out_d = {r_out_q[WIDTH-2:0], serial_in};
                if (r_cnt_q == c_CNT_LAST) begin
                    w_cnt_d   = '0;
                    w_busy_d  = 1'b0;
                    w_done_d  = 1'b1;
                    w_state_d = S_IDLE;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state_q <= S_IDLE;
            r_out_q   <= '0;
            r_cnt_q   <= '0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_out_q   <= w_out_d;
            r_cnt_q   <= w_cnt_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    assign out     = r_out_q;
    assign msb_out = r_out_q[WIDTH-1];
    assign lsb_out = r_out_q[0];
    assign busy    = r_busy_q;
    assign done    = r_done_q;

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_reg_param.sv
// ============================================================================
//  Module      : tb_universal_shift_reg_param
//  Description : Self-checking bench for universal_shift_reg_param at WIDTH 2/8/32.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_universal_shift_reg_param;

    logic        clk;
    logic        reset;
    logic        en;
    logic [2:0]  sel;
    logic        serial_in;
    logic [31:0] inp;

    logic [1:0]  out2;
    logic [7:0]  out8;
    logic [31:0] out32;
    logic        msb2, lsb2, busy2, done2;
    logic        msb8, lsb8, busy8, done8;
    logic        msb32, lsb32, busy32, done32;

    int n_checks = 0;
    int n_pass   = 0;

    universal_shift_reg_param #(.WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .en(en), .sel(sel), .serial_in(serial_in),
        .inp(inp[1:0]), .out(out2), .msb_out(msb2), .lsb_out(lsb2),
        .busy(busy2), .done(done2)
    );

    universal_shift_reg_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .en(en), .sel(sel), .serial_in(serial_in),
        .inp(inp[7:0]), .out(out8), .msb_out(msb8), .lsb_out(lsb8),
        .busy(busy8), .done(done8)
    );

    universal_shift_reg_param #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .en(en), .sel(sel), .serial_in(serial_in),
        .inp(inp), .out(out32), .msb_out(msb32), .lsb_out(lsb32),
        .busy(busy32), .done(done32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: register value as an integer plus a count of burst shifts.
    typedef struct {
        logic [31:0] val;
        bit          busy;
        bit          done;
        int          shifts;
    } mdl_t;

    mdl_t     mdl [3];
    const int c_W [3] = '{2, 8, 32};

    function automatic mdl_t model_step(mdl_t m, int w, bit r, bit e, logic [2:0] s,
                                        bit si, logic [31:0] d);
        logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        logic [31:0] top  = 32'd1 << (w - 1);
        logic [31:0] sib  = {31'd0, si};
        mdl_t n = m;
        n.done = 1'b0;
        if (!r) begin
            n.val = '0; n.busy = 1'b0; n.shifts = 0;
        end else if (m.busy) begin
            n.val    = ((m.val << 1) | sib) & mask;
            n.shifts = m.shifts + 1;
            if (n.shifts == w) begin
                n.busy = 1'b0; n.done = 1'b1; n.shifts = 0;
            end
        end else if (e) begin
            case (s)
                3'd1: n.val = ((m.val << 1) | sib) & mask;
                3'd2: n.val = (m.val >> 1) | (si ? top : 32'd0);
                3'd3: n.val = d & mask;
                3'd4: n.val = ((m.val << 1) | (((m.val & top) != 0) ? 32'd1 : 32'd0)) & mask;
                3'd5: n.val = (m.val >> 1) | (m.val[0] ? top : 32'd0);
                3'd6: n.val = (m.val >> 1) | (m.val & top);
                3'd7: begin
                    n.val = d & mask; n.busy = 1'b1; n.shifts = 0;
                end
                default: n.val = m.val;
            endcase
        end
        return n;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_dut(int i);
        logic [31:0] a_out;
        logic        a_msb, a_lsb, a_busy, a_done;
        int          w = c_W[i];
        case (i)
            0:       begin a_out = {30'd0, out2}; a_msb = msb2;  a_lsb = lsb2;  a_busy = busy2;  a_done = done2;  end
            1:       begin a_out = {24'd0, out8}; a_msb = msb8;  a_lsb = lsb8;  a_busy = busy8;  a_done = done8;  end
            default: begin a_out = out32;         a_msb = msb32; a_lsb = lsb32; a_busy = busy32; a_done = done32; end
        endcase
        check($sformatf("w%0d_out", w),  a_out, mdl[i].val);
        check($sformatf("w%0d_msb", w),  {31'd0, a_msb}, (mdl[i].val >> (w - 1)) & 32'd1);
        check($sformatf("w%0d_lsb", w),  {31'd0, a_lsb}, mdl[i].val & 32'd1);
        check($sformatf("w%0d_busy", w), {31'd0, a_busy}, {31'd0, mdl[i].busy});
        check($sformatf("w%0d_done", w), {31'd0, a_done}, {31'd0, mdl[i].done});
    endtask

    // Apply one cycle of inputs to all three widths, advance the model, compare.
    task automatic tick(bit r, bit e, logic [2:0] s, bit si, logic [31:0] d);
        reset = r; en = e; sel = s; serial_in = si; inp = d;
        @(posedge clk);
        for (int i = 0; i < 3; i++)
            mdl[i] = model_step(mdl[i], c_W[i], r, e, s, si, d);
        #1;
        for (int i = 0; i < 3; i++) check_dut(i);
    endtask

    typedef struct {
        bit         rst_n;
        bit         en;
        logic [2:0] sel;
        bit         si;
        logic [7:0] inp;
        logic [7:0] exp_out;
        bit         exp_busy;
    } vec_t;

    vec_t vecs [15];

    initial begin
        bit          pat [8];
        logic [7:0]  wd;
        int          bl2, bl8, bl32, dn2, dn8, dn32;

        vecs[0]  = '{1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 3'd3, 1'b0, 8'h96, 8'h96, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 3'd1, 1'b1, 8'h00, 8'h2D, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 3'd5, 1'b0, 8'h00, 8'h96, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 3'd6, 1'b0, 8'h00, 8'hCB, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 3'd4, 1'b0, 8'h00, 8'h97, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 3'd2, 1'b0, 8'h00, 8'h4B, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 3'd0, 1'b1, 8'hFF, 8'h4B, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 3'd3, 1'b0, 8'hA5, 8'hA5, 1'b0};
        for (int i = 9; i < 14; i++)
            vecs[i] = '{1'b1, 1'b0, 3'd1, 1'b1, 8'h00, 8'hA5, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 3'd2, 1'b1, 8'h00, 8'hD2, 1'b0};

        for (int i = 0; i < 3; i++) mdl[i] = '{32'd0, 1'b0, 1'b0, 0};
        reset = 1'b0; en = 1'b0; sel = 3'd0; serial_in = 1'b0; inp = '0;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            tick(vecs[i].rst_n, vecs[i].en, vecs[i].sel, vecs[i].si,
                 {$urandom, 24'd0} | {24'd0, vecs[i].inp});
            check($sformatf("vec%0d_out", i), {24'd0, out8}, {24'd0, vecs[i].exp_out});
            check($sformatf("vec%0d_busy", i), {31'd0, busy8}, {31'd0, vecs[i].exp_busy});
        end

        // Burst of 0xC3 with noisy en/sel/inp during the burst.
        pat = '{1, 0, 1, 1, 0, 0, 0, 1};
        wd  = 8'hC3;
        tick(1'b1, 1'b1, 3'd7, 1'b0, {24'd0, wd});
        check("burst_start_busy", {31'd0, busy8}, 32'd1);
        check("burst_msb0", {31'd0, msb8}, {31'd0, wd[7]});
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'($urandom), 3'($urandom), pat[k-1], $urandom);
            if (k < 8) begin
                check($sformatf("burst_msb%0d", k), {31'd0, msb8}, {31'd0, wd[7-k]});
                check($sformatf("burst_busy%0d", k), {31'd0, busy8}, 32'd1);
            end
        end
        check("burst_done", {31'd0, done8}, 32'd1);
        check("burst_final", {24'd0, out8}, 32'h0000_00B1);

        // Back-to-back: new burst issued in the done cycle.
        wd = 8'h5A;
        tick(1'b1, 1'b1, 3'd7, 1'b0, {24'd0, wd});
        check("b2b_busy", {31'd0, busy8}, 32'd1);
        check("b2b_msb0", {31'd0, msb8}, {31'd0, wd[7]});
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b0, 3'd0, 1'($urandom), '0);
            if (k < 8) check($sformatf("b2b_msb%0d", k), {31'd0, msb8}, {31'd0, wd[7-k]});
        end
        check("b2b_done", {31'd0, done8}, 32'd1);

        // Reset mid-burst: abort with no done pulse afterwards.
        tick(1'b1, 1'b1, 3'd7, 1'b1, 32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 3'd0, 1'b1, '0);
        tick(1'b0, 1'b1, 3'd7, 1'b1, '1);
        check("rst_mid_out", {24'd0, out8}, 32'd0);
        check("rst_mid_busy", {31'd0, busy8}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b0, 3'd0, 1'b1, '0);
            check($sformatf("rst_mid_nodone%0d", k), {31'd0, done8}, 32'd0);
        end

        // Burst length per width: busy high for WIDTH cycles, one done pulse.
        tick(1'b1, 1'b1, 3'd7, 1'($urandom), $urandom);
        bl2 = int'(busy2); bl8 = int'(busy8); bl32 = int'(busy32);
        dn2 = 0; dn8 = 0; dn32 = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1'b1, 1'b0, 3'd0, 1'($urandom), '0);
            bl2 += int'(busy2); bl8 += int'(busy8); bl32 += int'(busy32);
            dn2 += int'(done2); dn8 += int'(done8); dn32 += int'(done32);
        end
        check("w2_busy_len",  bl2,  2);
        check("w8_busy_len",  bl8,  8);
        check("w32_busy_len", bl32, 32);
        check("w2_done_cnt",  dn2,  1);
        check("w8_done_cnt",  dn8,  1);
        check("w32_done_cnt", dn32, 1);

        // Randomized traffic against the model, with occasional resets.
        for (int k = 0; k < 600; k++)
            tick(($urandom_range(0, 59) != 0), ($urandom_range(0, 4) != 0),
                 3'($urandom), 1'($urandom), $urandom);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
